// File: rtl/fre_lst.sv
// Physical-register free list: circular FIFO of unallocated preg indices with a
// single-level checkpoint of the allocation (head) pointer for branch recovery.
module fre_lst #(
    parameter int unsigned PREG_NUM  = 64,
    parameter int unsigned PREG_BITS = 6,
    parameter int unsigned LREG_NUM  = 16,
    parameter int unsigned CNT_BITS  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req_i,
    output logic                 alloc_vld_o,
    output logic [PREG_BITS-1:0] alloc_preg_o,
    input  logic [PREG_BITS:0]   fre_preg_i,
    input  logic                 chk_sav_i,
    input  logic                 chk_rst_i,
    output logic [CNT_BITS-1:0]  fre_cnt_o,
    output logic                 err_o
);

    logic [PREG_BITS-1:0] mem_q [PREG_NUM];
    logic [PREG_BITS-1:0] hd_q, hd_d;
    logic [PREG_BITS-1:0] tl_q, tl_d;
    logic [PREG_BITS-1:0] chk_q, chk_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 alloc;
    logic                 rel;
    logic                 full;
    logic                 drop;
    logic                 rel_ok;
    logic [PREG_BITS-1:0] rb_dist;

    assign alloc_vld_o  = (cnt_q != '0) && !chk_rst_i;
    assign alloc_preg_o = mem_q[hd_q];
    assign fre_cnt_o    = cnt_q;
    assign err_o        = err_q;

    assign alloc   = alloc_req_i && alloc_vld_o;
    assign rel     = fre_preg_i[PREG_BITS];
    assign full    = (cnt_q == CNT_BITS'(PREG_NUM));
    // A release into a full list only fits if the head moves out of the way.
    assign drop    = rel && full && !alloc;
    assign rel_ok  = rel && !drop;
    assign rb_dist = hd_q - chk_q;

    always_comb begin
        hd_d  = hd_q;
        chk_d = chk_q;
        cnt_d = cnt_q;
        err_d = err_q | drop;
        tl_d  = tl_q + PREG_BITS'(rel_ok);
        if (chk_rst_i) begin
            // Entries between chk and hd are still intact; just rewind the head.
            hd_d  = chk_q;
            cnt_d = cnt_q + CNT_BITS'(rb_dist) + CNT_BITS'(rel_ok);
        end else begin
            hd_d  = hd_q + PREG_BITS'(alloc);
            cnt_d = cnt_q + CNT_BITS'(rel_ok) - CNT_BITS'(alloc);
            if (chk_sav_i) begin
                chk_d = hd_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_q  <= '0;
            tl_q  <= PREG_BITS'(PREG_NUM - LREG_NUM);
            chk_q <= '0;
            cnt_q <= CNT_BITS'(PREG_NUM - LREG_NUM);
            err_q <= 1'b0;
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            chk_q <= chk_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PREG_NUM); i++) begin
                mem_q[i] <= PREG_BITS'((i + int'(LREG_NUM)) % int'(PREG_NUM));
            end
        end else if (rel_ok) begin
            mem_q[tl_q] <= fre_preg_i[PREG_BITS-1:0];
        end
    end

endmodule

// File: tb/tb_fre_lst.sv
// Bench for fre_lst: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a queue-based model of the free list.
module tb_fre_lst;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_req_i = 1'b0;
    logic       alloc_vld_o;
    logic [5:0] alloc_preg_o;
    logic [6:0] fre_preg_i = '0;
    logic       chk_sav_i = 1'b0;
    logic       chk_rst_i = 1'b0;
    logic [6:0] fre_cnt_o;
    logic       err_o;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: free pregs in hand-out order, and pregs handed out since the checkpoint.
    logic [5:0] fl[$];
    logic [5:0] since[$];
    bit         m_err;

    fre_lst dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req_i  (alloc_req_i),
        .alloc_vld_o  (alloc_vld_o),
        .alloc_preg_o (alloc_preg_o),
        .fre_preg_i   (fre_preg_i),
        .chk_sav_i    (chk_sav_i),
        .chk_rst_i    (chk_rst_i),
        .fre_cnt_o    (fre_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        since.delete();
        for (int i = 16; i < 64; i++) fl.push_back(6'(i));
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit req, input logic [6:0] fre, input bit sav, input bit rs);
        int pre;
        bit ea;
        bit full;
        pre  = fl.size();
        ea   = req && (pre > 0) && !rs;
        full = (pre == 64) && !ea;
        if (rs) begin
            fl = {since, fl};
            since.delete();
        end else begin
            if (ea) since.push_back(fl.pop_front());
            if (sav) since.delete();
        end
        if (fre[6]) begin
            if (full) m_err = 1'b1;
            else fl.push_back(fre[5:0]);
        end
    endtask

    task automatic cyc(input bit req, input logic [6:0] fre, input bit sav, input bit rs);
        alloc_req_i = req;
        fre_preg_i  = fre;
        chk_sav_i   = sav;
        chk_rst_i   = rs;
        @(posedge clk);
        model_step(req, fre, sav, rs);
        #1;
    endtask

    task automatic do_reset();
        chk_en      = 1'b0;
        alloc_req_i = 1'b0;
        fre_preg_i  = '0;
        chk_sav_i   = 1'b0;
        chk_rst_i   = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_vld;
            exp_vld = (fl.size() != 0) && !chk_rst_i;
            check("alloc_vld", int'(alloc_vld_o), int'(exp_vld));
            if (exp_vld) check("alloc_preg", int'(alloc_preg_o), int'(fl[0]));
            check("fre_cnt", int'(fre_cnt_o), fl.size());
            check("err", int'(err_o), int'(m_err));
        end
    end

    initial begin
        // Drain the list after reset.
        do_reset();
        check("rst_vld", int'(alloc_vld_o), 1);
        check("rst_preg", int'(alloc_preg_o), 16);
        check("rst_cnt", int'(fre_cnt_o), 48);
        check("rst_err", int'(err_o), 0);
        for (int i = 0; i < 48; i++) begin
            check("drain_preg", int'(alloc_preg_o), 16 + i);
            cyc(1'b1, 7'h00, 1'b0, 1'b0);
        end
        check("empty_vld", int'(alloc_vld_o), 0);
        check("empty_cnt", int'(fre_cnt_o), 0);

        // Release into empty list: no bypass, visible next cycle.
        cyc(1'b1, {1'b1, 6'd5}, 1'b0, 1'b0);
        check("refill_vld", int'(alloc_vld_o), 1);
        check("refill_preg", int'(alloc_preg_o), 5);
        check("refill_cnt", int'(fre_cnt_o), 1);

        // Steady allocate + release, pointers wrap.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (i == 48) check("wrap_preg", int'(alloc_preg_o), 3);
            cyc(1'b1, {1'b1, 6'd3}, 1'b0, 1'b0);
        end
        check("wrap_cnt", int'(fre_cnt_o), 48);

        // Checkpoint save and restore with simultaneous release.
        do_reset();
        cyc(1'b1, 7'h00, 1'b0, 1'b0);
        cyc(1'b1, 7'h00, 1'b0, 1'b0);
        cyc(1'b0, 7'h00, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 7'h00, 1'b0, 1'b0);
        check("pre_rst_preg", int'(alloc_preg_o), 21);
        cyc(1'b1, {1'b1, 6'd7}, 1'b0, 1'b1);
        check("restore_preg", int'(alloc_preg_o), 18);
        check("restore_cnt", int'(fre_cnt_o), 47);

        // Overflow: fill to 64, one more release is dropped and sets err.
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1'b0, {1'b1, 6'(k)}, 1'b0, 1'b0);
        check("full_cnt", int'(fre_cnt_o), 64);
        cyc(1'b0, {1'b1, 6'd50}, 1'b0, 1'b0);
        check("ovf_err", int'(err_o), 1);
        check("ovf_cnt", int'(fre_cnt_o), 64);
        for (int i = 0; i < 48; i++) begin
            check("ovf_drain", int'(alloc_preg_o), 16 + i);
            cyc(1'b1, 7'h00, 1'b0, 1'b0);
        end
        check("ovf_first_rel", int'(alloc_preg_o), 0);
        repeat (3) cyc(1'b1, {1'b1, 6'd9}, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle, away from any clock edge.
        #1;
        chk_en      = 1'b0;
        alloc_req_i = 1'b0;
        fre_preg_i  = '0;
        rst_n       = 1'b0;
        #1;
        check("async_cnt", int'(fre_cnt_o), 48);
        check("async_preg", int'(alloc_preg_o), 16);
        check("async_err", int'(err_o), 0);
        check("async_vld", int'(alloc_vld_o), 1);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Randomized traffic, alternating drain-heavy and fill-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            bit         req;
            bit         sav;
            bit         rs;
            logic [6:0] fre;
            bit         drain;
            drain = ((i / 150) % 2) == 0;
            req   = drain ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            fre   = '0;
            if ((drain ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8)) &&
                ((fl.size() + since.size() < 64) || since.size() == 0)) begin
                fre = {1'b1, 6'($urandom_range(0, 63))};
            end
            sav = ($urandom_range(0, 7) == 0);
            rs  = ($urandom_range(0, 15) == 0) && (since.size() < 64) &&
                  (fl.size() + since.size() + int'(fre[6]) <= 64);
            cyc(req, fre, sav, rs);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fre_lst.md
# fre_lst

Physical-register free list for the rename stage. Holds indices of unallocated physical registers in a circular FIFO, hands one out per cycle to the rename/issue-queue load path as the new destination `pdst`, and takes back the 7-bit `{valid, preg}` release word produced per issue-queue line when a mapping is overwritten. A single-level checkpoint of the allocation pointer lets the front end return all registers allocated after a mispredicted branch in one cycle.

## Interface
- `PREG_NUM`, 64: physical registers and FIFO depth.
- `PREG_BITS`, 6: physical register index width.
- `LREG_NUM`, 16: logical registers; pregs 0..LREG_NUM-1 are architecturally mapped at reset.
- `CNT_BITS`, 7: occupancy counter width, range 0..PREG_NUM.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `alloc_req` in 1: rename wants a destination preg this cycle.
- `alloc_vld` out 1: a free preg is available; allocation happens when `alloc_req && alloc_vld`.
- `alloc_preg` out PREG_BITS: preg index at FIFO head.
- `fre_preg` in PREG_BITS+1: bit 6 = release valid, bits 5:0 = preg index being freed.
- `chk_sav` in 1: save checkpoint of allocation pointer.
- `chk_rst` in 1: restore allocation pointer to checkpoint.
- `fre_cnt` out CNT_BITS: current number of free pregs.
- `err` out 1: sticky overflow error.

## Operation
- Storage: PREG_NUM x PREG_BITS array `mem`, head pointer `hd`, tail pointer `tl` (PREG_BITS each, wrap mod PREG_NUM), counter `cnt`, checkpoint pointer `chk_ptr`.
- Reset: `mem[i] = (i + LREG_NUM) mod PREG_NUM` for all i; `hd=0`, `tl=PREG_NUM-LREG_NUM` (48), `cnt=48`, `chk_ptr=0`, `err=0`. Outputs after reset: `alloc_vld=1`, `alloc_preg=16`, `fre_cnt=48`, `err=0`.
- `alloc_preg = mem[hd]` combinationally; `alloc_vld = (cnt != 0) && !chk_rst`.
- Allocate (`alloc_req && alloc_vld`): `hd <= hd+1`, `cnt` decrements.
- Release (`fre_preg[6]`): `mem[tl] <= fre_preg[5:0]`, `tl <= tl+1`, `cnt` increments. Release index is not checked for duplicates.
- Allocate and release in the same cycle: both pointers advance, `cnt` unchanged.
- Empty (`cnt==0`): `alloc_vld=0`; a release arriving that cycle is written but not bypassed; allocation possible next cycle.
- Full (`cnt==PREG_NUM`) with release and no allocate: write dropped, pointers and `cnt` unchanged, `err <= 1`. `err` clears only on reset.
- `chk_sav` (without `chk_rst`): `chk_ptr <=` the post-update head, i.e. `hd+1` if allocating this cycle, else `hd`.
- `chk_rst`: `hd <= chk_ptr`; `cnt <= cnt + ((hd - chk_ptr) mod PREG_NUM) + release`. Allocation blocked that cycle; release still accepted. `chk_rst` has priority over `chk_sav`; `chk_ptr` unchanged. Entries between `chk_ptr` and `hd` are still intact, because depth equals PREG_NUM and the tail cannot overtake them.
- `fre_cnt = cnt`.

## Timing
- Allocation has zero latency. `alloc_preg` is valid in the same cycle as `alloc_vld`, and the next index appears after the clock edge.
- A release is visible to allocation no earlier than the cycle after it is presented. When the list was empty, `alloc_vld` rises exactly one cycle after the release.
- Restore takes effect on the edge: in the cycle after `chk_rst`, `alloc_preg = mem[chk_ptr]`.
- Reset is asynchronous: assertion mid-operation immediately forces all state and outputs to their reset values, discarding in-flight allocate/release.

## Test plan
- Reset, then `alloc_req=1` for 48 cycles -> `alloc_preg` = 16,17,...,63; then `alloc_vld=0`, `fre_cnt=0`.
- From empty, release preg 5 -> next cycle `alloc_vld=1`, `alloc_preg=5`, `fre_cnt=1`; no allocation in the release cycle.
- From reset, allocate and release preg 3 every cycle for 100 cycles -> `fre_cnt` stays 48, pointers wrap, and preg 3 reappears at the head after 48 allocations.
- After reset, allocate 2 (16,17), pulse `chk_sav`, allocate 3 (18,19,20), pulse `chk_rst` with a simultaneous release of preg 7 -> next cycle `alloc_preg=18`, `fre_cnt=47` (43+3+1).
- Release 16 pregs from reset (reaching 64), then release one more -> `err=1`, `fre_cnt=64`, and the next 48 allocations return 16..63 with the first stored release following.
- Assert `rst_n=0` mid-stream asynchronously -> `fre_cnt=48`, `alloc_preg=16`, `err=0` without waiting for a clock edge.
